// File: rtl/subckt_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : subckt_seq_pkg
// Purpose  : Shared types and constants for the subcircuit vector sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package subckt_seq_pkg;

  // Default width of the vector / mismatch / first-fail counters.
  localparam int C_CNT_W_DEF = 16;

  // "No mismatch seen yet" marker for first_fail at the default width.
  localparam logic [C_CNT_W_DEF-1:0] NO_FAIL = {C_CNT_W_DEF{1'b1}};

  // Sequencer run phases.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_READY = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

endpackage : subckt_seq_pkg
`default_nettype wire

// File: rtl/seq_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : seq_sat_counter
// Purpose  : Clearable up-counter that sticks at all-ones instead of wrapping.
//            Also exposes the value it will take at the next edge.
// Revision : 1.0 - initial release
// ============================================================================
module seq_sat_counter
  import subckt_seq_pkg::*;
#(
  parameter int CNT_W = C_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Next value: clear wins over increment; increment stops at all-ones.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr) begin
      w_cnt_nxt = '0;
    end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign cnt     = r_cnt;
  assign cnt_nxt = w_cnt_nxt;

endmodule : seq_sat_counter
`default_nettype wire

// File: rtl/subckt_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : subckt_vector_sequencer
// Purpose  : Applies stimulus/expected pairs to a small gate-level DUT, holds
//            each stimulus LAT cycles, compares the response and keeps
//            mismatch statistics for trojan screening.
// Revision : 1.0 - initial release
// ============================================================================
module subckt_vector_sequencer
  import subckt_seq_pkg::*;
#(
  parameter int DIN_W      = 3,
  parameter int DOUT_W     = 1,
  parameter int LAT        = 2,
  parameter int FLUSH_CYC  = 2,
  parameter int CNT_W      = C_CNT_W_DEF,
  parameter int SUSPECT_TH = 1
) (
  input  logic              seq_clk,
  input  logic              seq_rst,
  input  logic              start,
  input  logic              abort,
  input  logic              vec_valid,
  output logic              vec_ready,
  input  logic [DIN_W-1:0]  vec_stim,
  input  logic [DOUT_W-1:0] vec_exp,
  input  logic              vec_last,
  output logic [DIN_W-1:0]  dut_in,
  output logic              dut_rst,
  input  logic [DOUT_W-1:0] dut_out,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  vec_cnt,
  output logic [CNT_W-1:0]  mis_cnt,
  output logic [CNT_W-1:0]  first_fail,
  output logic              suspect
);

  localparam int               C_FLUSH_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [C_FLUSH_W-1:0] C_FLUSH_LOAD = C_FLUSH_W'(FLUSH_CYC - 1);
  localparam logic [3:0]       C_LAT        = 4'(LAT);
  localparam logic [CNT_W-1:0] C_NO_FAIL    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_SUSPECT_TH = CNT_W'(SUSPECT_TH);

  seq_state_t             r_state;
  seq_state_t             w_state_nxt;
  logic [C_FLUSH_W-1:0]   r_flush_cnt;
  logic [3:0]             r_hold_cnt;
  logic [DOUT_W-1:0]      r_exp;
  logic                   r_last;
  logic [DIN_W-1:0]       r_dut_in;
  logic [CNT_W-1:0]       r_vec_cnt;
  logic [CNT_W-1:0]       r_first_fail;
  logic                   r_suspect;
  logic [CNT_W-1:0]       w_mis_cnt;
  logic [CNT_W-1:0]       w_mis_nxt;

  logic w_start;
  logic w_accept;
  logic w_sample;
  logic w_mismatch;

  // A start only counts from IDLE; abort never blocks it there.
  assign w_start    = (r_state == ST_IDLE) && start;
  // abort beats both accepting a new vector and sampling the current one.
  assign w_accept   = (r_state == ST_READY) && vec_valid && !abort;
  assign w_sample   = (r_state == ST_HOLD) && (r_hold_cnt == C_LAT) && !abort;
  assign w_mismatch = w_sample && (dut_out != r_exp);

  // State register.
  always_ff @(posedge seq_clk) begin
    if (seq_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    w_state_nxt = r_state;
    vec_ready   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    dut_rst     = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        busy = 1'b1;
        if (abort)                   w_state_nxt = ST_IDLE;
        else if (r_flush_cnt == '0)  w_state_nxt = ST_READY;
      end
      ST_READY: begin
        busy      = 1'b1;
        vec_ready = 1'b1;
        dut_rst   = 1'b0;
        if (abort)          w_state_nxt = ST_IDLE;
        else if (vec_valid) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        busy    = 1'b1;
        dut_rst = 1'b0;
        if (abort)                    w_state_nxt = ST_IDLE;
        else if (r_hold_cnt == C_LAT) w_state_nxt = r_last ? ST_DONE : ST_READY;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Flush timer: loaded on start, counts down through FLUSH.
  always_ff @(posedge seq_clk) begin
    if (seq_rst) begin
      r_flush_cnt <= '0;
    end else if (w_start) begin
      r_flush_cnt <= C_FLUSH_LOAD;
    end else if ((r_state == ST_FLUSH) && (r_flush_cnt != '0)) begin
      r_flush_cnt <= r_flush_cnt - 1'b1;
    end
  end

  // Vector capture and hold timer; stimulus is forced to zero whenever idle.
  always_ff @(posedge seq_clk) begin
    if (seq_rst) begin
      r_dut_in   <= '0;
      r_exp      <= '0;
      r_last     <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      if (w_state_nxt == ST_IDLE) begin
        r_dut_in <= '0;
      end else if (w_accept) begin
        r_dut_in <= vec_stim;
      end
      if (w_accept) begin
        r_exp      <= vec_exp;
        r_last     <= vec_last;
        r_hold_cnt <= '0;
      end else if (r_state == ST_HOLD) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
    end
  end

  // Run statistics: cleared on start, updated at each sample edge.
  always_ff @(posedge seq_clk) begin
    if (seq_rst) begin
      r_vec_cnt    <= '0;
      r_first_fail <= C_NO_FAIL;
      r_suspect    <= 1'b0;
    end else if (w_start) begin
      r_vec_cnt    <= '0;
      r_first_fail <= C_NO_FAIL;
      r_suspect    <= 1'b0;
    end else if (w_sample) begin
      r_vec_cnt <= r_vec_cnt + 1'b1;
      // A wrapped index equal to all-ones cannot be told apart from "none".
      if (w_mismatch && (r_first_fail == C_NO_FAIL)) begin
        r_first_fail <= r_vec_cnt;
      end
      if (w_mismatch && (w_mis_nxt >= C_SUSPECT_TH)) begin
        r_suspect <= 1'b1;
      end
    end
  end

  seq_sat_counter #(
    .CNT_W (CNT_W)
  ) u_mis_cnt (
    .clk     (seq_clk),
    .rst     (seq_rst),
    .clr     (w_start),
    .inc     (w_mismatch),
    .cnt     (w_mis_cnt),
    .cnt_nxt (w_mis_nxt)
  );

  assign dut_in     = r_dut_in;
  assign vec_cnt    = r_vec_cnt;
  assign mis_cnt    = w_mis_cnt;
  assign first_fail = r_first_fail;
  assign suspect    = r_suspect;

endmodule : subckt_vector_sequencer
`default_nettype wire

// File: tb/tb_subckt_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_subckt_vector_sequencer
// Purpose  : Self-checking bench; instance A (LAT=2) drives a 2-flop DUT
//            model, instance B (LAT=0) drives a combinational DUT model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_subckt_vector_sequencer;
  import subckt_seq_pkg::*;

  logic clk;
  logic rst;

  // Instance A signals
  logic        start_a, abort_a, valid_a, ready_a, exp_a, last_a;
  logic [2:0]  stim_a, din_a;
  logic        drst_a, dout_a, busy_a, done_a, sus_a;
  logic [15:0] vcnt_a, mcnt_a, ff_a;

  // Instance B signals
  logic        start_b, abort_b, valid_b, ready_b, exp_b, last_b;
  logic [2:0]  stim_b, din_b;
  logic        drst_b, dout_b, busy_b, done_b, sus_b;
  logic [15:0] vcnt_b, mcnt_b, ff_b;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [15:0] m_vec, m_mis, m_ff;
  logic        m_sus;

  logic [2:0] t_stim[16];
  logic       t_exp[16];

  subckt_vector_sequencer #(.DIN_W(3), .DOUT_W(1), .LAT(2), .FLUSH_CYC(2),
                            .CNT_W(16), .SUSPECT_TH(1)) u_dut_a (
    .seq_clk(clk), .seq_rst(rst), .start(start_a), .abort(abort_a),
    .vec_valid(valid_a), .vec_ready(ready_a), .vec_stim(stim_a),
    .vec_exp(exp_a), .vec_last(last_a), .dut_in(din_a), .dut_rst(drst_a),
    .dut_out(dout_a), .busy(busy_a), .done(done_a), .vec_cnt(vcnt_a),
    .mis_cnt(mcnt_a), .first_fail(ff_a), .suspect(sus_a)
  );

  subckt_vector_sequencer #(.DIN_W(3), .DOUT_W(1), .LAT(0), .FLUSH_CYC(2),
                            .CNT_W(16), .SUSPECT_TH(1)) u_dut_b (
    .seq_clk(clk), .seq_rst(rst), .start(start_b), .abort(abort_b),
    .vec_valid(valid_b), .vec_ready(ready_b), .vec_stim(stim_b),
    .vec_exp(exp_b), .vec_last(last_b), .dut_in(din_b), .dut_rst(drst_b),
    .dut_out(dout_b), .busy(busy_b), .done(done_b), .vec_cnt(vcnt_b),
    .mis_cnt(mcnt_b), .first_fail(ff_b), .suspect(sus_b)
  );

  // Subcircuit under test for A: s[1:0] through two flops, s[2] direct.
  logic [1:0] p1_a, p2_a;
  always @(posedge clk) begin
    if (drst_a) begin
      p1_a <= 2'b00;
      p2_a <= 2'b00;
    end else begin
      p1_a <= din_a[1:0];
      p2_a <= p1_a;
    end
  end
  assign dout_a = ~din_a[2] & (p2_a[1] | p2_a[0]);

  // Subcircuit under test for B: purely combinational.
  assign dout_b = ~din_b[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_a(input logic [2:0] s);
    return ~s[2] & (s[1] | s[0]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({din_a, drst_a, ready_a, busy_a, done_a, sus_a} !== {3'b000, 1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL reset_ctl: got din=%0h rst=%0b rdy=%0b busy=%0b done=%0b sus=%0b want 0,1,0,0,0,0",
               din_a, drst_a, ready_a, busy_a, done_a, sus_a);
    end
    checks++;
    if ({vcnt_a, mcnt_a, ff_a} !== {16'h0, 16'h0, NO_FAIL}) begin
      errors++;
      $display("FAIL reset_cnt: got vec=%0h mis=%0h ff=%0h want 0 0 ffff", vcnt_a, mcnt_a, ff_a);
    end
    rst = 1'b0;
    tick();
  endtask

  // Runs n vectors from t_stim/t_exp on instance A. With gaps set, valid is
  // dropped for one READY cycle before every vector. abort_idx < n aborts
  // that vector in its last HOLD cycle.
  task automatic run_a(input int n, input bit gaps, input int abort_idx);
    int         rst_cyc;
    logic [2:0] s;
    logic [2:0] prev;
    logic       e;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    m_vec = 16'h0; m_mis = 16'h0; m_ff = NO_FAIL; m_sus = 1'b0;
    checks++;
    if ({busy_a, vcnt_a, mcnt_a, ff_a, sus_a} !== {1'b1, 16'h0, 16'h0, NO_FAIL, 1'b0}) begin
      errors++;
      $display("FAIL start_clear: got busy=%0b vec=%0h mis=%0h ff=%0h sus=%0b want 1 0 0 ffff 0",
               busy_a, vcnt_a, mcnt_a, ff_a, sus_a);
    end
    rst_cyc = 0;
    while (drst_a && rst_cyc < 20) begin
      rst_cyc++;
      tick();
    end
    checks++;
    if (rst_cyc != 2 || ready_a !== 1'b1) begin
      errors++;
      $display("FAIL flush_len: got %0d cycles rdy=%0b want 2 cycles rdy=1", rst_cyc, ready_a);
    end
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        valid_a = 1'b0;
        prev = din_a;
        tick();
        checks++;
        if (ready_a !== 1'b1 || din_a !== prev) begin
          errors++;
          $display("FAIL idle_ready: got rdy=%0b din=%0h want 1 %0h", ready_a, din_a, prev);
        end
      end
      s = t_stim[i];
      e = t_exp[i];
      valid_a = 1'b1; stim_a = s; exp_a = e; last_a = (i == n - 1);
      tick();
      valid_a = 1'b0; stim_a = 3'($urandom); exp_a = 1'($urandom); last_a = 1'($urandom);
      for (int k = 1; k <= 3; k++) begin
        checks++;
        if (ready_a !== 1'b0 || din_a !== s || drst_a !== 1'b0 || vcnt_a !== m_vec) begin
          errors++;
          $display("FAIL hold[%0d.%0d]: got rdy=%0b din=%0h rst=%0b vec=%0d want 0 %0h 0 %0d",
                   i, k, ready_a, din_a, drst_a, vcnt_a, s, m_vec);
        end
        if (i == abort_idx && k == 3) begin
          abort_a = 1'b1;
          tick();
          abort_a = 1'b0;
          checks++;
          if ({busy_a, drst_a, done_a, din_a} !== {1'b0, 1'b1, 1'b0, 3'b000} || vcnt_a !== m_vec) begin
            errors++;
            $display("FAIL abort: got busy=%0b rst=%0b done=%0b din=%0h vec=%0d want 0 1 0 0 %0d",
                     busy_a, drst_a, done_a, din_a, vcnt_a, m_vec);
          end
          return;
        end
        tick();
      end
      if (e !== ref_a(s)) begin
        m_mis = m_mis + 1;
        if (m_ff == NO_FAIL) m_ff = m_vec;
      end
      m_vec = m_vec + 1;
      m_sus = (m_mis >= 1);
      checks++;
      if ({vcnt_a, mcnt_a, ff_a, sus_a} !== {m_vec, m_mis, m_ff, m_sus}) begin
        errors++;
        $display("FAIL stats[%0d]: got vec=%0d mis=%0d ff=%0h sus=%0b want %0d %0d %0h %0b",
                 i, vcnt_a, mcnt_a, ff_a, sus_a, m_vec, m_mis, m_ff, m_sus);
      end
      if (i == n - 1) begin
        checks++;
        if ({done_a, busy_a, drst_a} !== 3'b101) begin
          errors++;
          $display("FAIL done_pulse: got done=%0b busy=%0b rst=%0b want 1 0 1", done_a, busy_a, drst_a);
        end
        tick();
        checks++;
        if ({done_a, busy_a, drst_a, din_a} !== {3'b001, 3'b000}) begin
          errors++;
          $display("FAIL done_end: got done=%0b busy=%0b rst=%0b din=%0h want 0 0 1 0",
                   done_a, busy_a, drst_a, din_a);
        end
      end else begin
        checks++;
        if (ready_a !== 1'b1 || done_a !== 1'b0) begin
          errors++;
          $display("FAIL back_ready[%0d]: got rdy=%0b done=%0b want 1 0", i, ready_a, done_a);
        end
      end
    end
  endtask

  task automatic test_clean_stream();
    for (int i = 0; i < 8; i++) begin
      t_stim[i] = 3'(i);
      t_exp[i]  = ref_a(3'(i));
    end
    run_a(8, 1'b0, 99);
  endtask

  task automatic test_mismatch_stream();
    for (int i = 0; i < 8; i++) begin
      t_stim[i] = 3'(i);
      t_exp[i]  = (i == 3) ? 1'b0 : ref_a(3'(i));
    end
    run_a(8, 1'b0, 99);
  endtask

  task automatic test_valid_gaps();
    for (int i = 0; i < 10; i++) begin
      t_stim[i] = 3'($urandom);
      t_exp[i]  = ref_a(t_stim[i]) ^ ($urandom_range(0, 3) == 0);
    end
    run_a(10, 1'b1, 99);
  endtask

  task automatic test_abort();
    for (int i = 0; i < 8; i++) begin
      t_stim[i] = 3'($urandom);
      t_exp[i]  = ref_a(t_stim[i]);
    end
    run_a(8, 1'b0, 5);
    tick();
    checks++;
    if (vcnt_a !== 16'd5 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL abort_frozen: got vec=%0d busy=%0b done=%0b want 5 0 0", vcnt_a, busy_a, done_a);
    end
  endtask

  task automatic test_random_back_to_back();
    for (int i = 0; i < 12; i++) begin
      t_stim[i] = 3'($urandom);
      t_exp[i]  = ref_a(t_stim[i]) ^ ($urandom_range(0, 2) == 0);
    end
    run_a(12, 1'b0, 99);
  endtask

  task automatic test_reset_mid_hold();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    valid_a = 1'b1; stim_a = 3'b011; exp_a = 1'b0; last_a = 1'b0;
    tick();
    valid_a = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (mcnt_a !== 16'd1 || sus_a !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got mis=%0d sus=%0b want 1 1", mcnt_a, sus_a);
    end
    valid_a = 1'b1; stim_a = 3'b101; exp_a = 1'b1;
    tick();
    valid_a = 1'b0;
    rst = 1'b1; start_a = 1'b1;
    tick();
    rst = 1'b0; start_a = 1'b0;
    checks++;
    if ({din_a, drst_a, ready_a, busy_a, done_a, sus_a} !== {3'b000, 1'b1, 4'b0000} ||
        {vcnt_a, mcnt_a, ff_a} !== {16'h0, 16'h0, NO_FAIL}) begin
      errors++;
      $display("FAIL rst_mid_hold: got din=%0h rst=%0b rdy=%0b busy=%0b done=%0b sus=%0b vec=%0h mis=%0h ff=%0h want reset values",
               din_a, drst_a, ready_a, busy_a, done_a, sus_a, vcnt_a, mcnt_a, ff_a);
    end
    tick();
    checks++;
    if (busy_a !== 1'b0 || drst_a !== 1'b1) begin
      errors++;
      $display("FAIL rst_start_ignored: got busy=%0b rst=%0b want 0 1", busy_a, drst_a);
    end
  endtask

  task automatic test_lat0();
    logic [2:0] s;
    logic       e;
    int         bad;
    logic [15:0] bv, bm, bf;
    bad = $urandom_range(0, 3);
    bv = 16'h0; bm = 16'h0; bf = NO_FAIL;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    tick();
    checks++;
    if (ready_b !== 1'b1) begin
      errors++;
      $display("FAIL lat0_ready: got %0b want 1", ready_b);
    end
    for (int i = 0; i < 4; i++) begin
      s = 3'($urandom);
      e = ~s[2] ^ (i == bad);
      valid_b = 1'b1; stim_b = s; exp_b = e; last_b = (i == 3);
      tick();
      checks++;
      if (ready_b !== 1'b0 || din_b !== s || vcnt_b !== bv) begin
        errors++;
        $display("FAIL lat0_hold[%0d]: got rdy=%0b din=%0h vec=%0d want 0 %0h %0d", i, ready_b, din_b, vcnt_b, s, bv);
      end
      tick();
      if (e !== ~s[2]) begin
        bm = bm + 1;
        if (bf == NO_FAIL) bf = bv;
      end
      bv = bv + 1;
      checks++;
      if ({vcnt_b, mcnt_b, ff_b} !== {bv, bm, bf} || ready_b !== (i != 3) || done_b !== (i == 3)) begin
        errors++;
        $display("FAIL lat0_sample[%0d]: got vec=%0d mis=%0d ff=%0h rdy=%0b done=%0b want %0d %0d %0h %0b %0b",
                 i, vcnt_b, mcnt_b, ff_b, ready_b, done_b, bv, bm, bf, (i != 3), (i == 3));
      end
    end
    valid_b = 1'b0;
    tick();
    checks++;
    if (mcnt_b !== 16'd1 || done_b !== 1'b0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL lat0_end: got mis=%0d done=%0b busy=%0b want 1 0 0", mcnt_b, done_b, busy_b);
    end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; valid_a = 1'b0; stim_a = 3'b000; exp_a = 1'b0; last_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0; valid_b = 1'b0; stim_b = 3'b000; exp_b = 1'b0; last_b = 1'b0;
    test_reset();
    test_clean_stream();
    test_mismatch_stream();
    test_valid_gaps();
    test_abort();
    test_random_back_to_back();
    test_reset_mid_hold();
    test_lat0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_subckt_vector_sequencer
`default_nettype wire
